sdram_access_port: RTL and testbench

SDRAM_ACCESS_PORT -- requirements
Module: sdram_access_port

---
 rtl/sdram_access_pkg.sv | 16 +
 rtl/sdram_access_port_if.sv | 39 +++
 rtl/timeout_counter.sv | 28 ++
 rtl/sdram_access_port.sv | 121 ++++++++++++
 tb/tb_sdram_access_port.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/sdram_access_pkg.sv
// Shared types and default sizing for the SDRAM access port.
package sdram_access_pkg;

  localparam int unsigned ADDR_W_DEF  = 24;
  localparam int unsigned DATA_W_DEF  = 32;
  localparam int unsigned TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR_REQ,
    DONE
  } state_t;

endpackage

// File: rtl/sdram_access_port_if.sv
// Request side (controlUnit) plus Avalon-MM side of the SDRAM access port.
interface sdram_access_port_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned DATA_W = 32
);
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] read_data;
  logic              data_read;
  logic              write_done;
  logic              busy;
  logic              timeout_err;
  logic              overrun_err;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [DATA_W-1:0] avm_writedata;
  logic [DATA_W-1:0] avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  // The port itself: Avalon master toward SDRAM.
  modport master (
    input  read_en, write_en, address, write_data,
    output read_data, data_read, write_done, busy, timeout_err, overrun_err,
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  // Environment view: request source and Avalon slave.
  modport slave (
    output read_en, write_en, address, write_data,
    input  read_data, data_read, write_done, busy, timeout_err, overrun_err,
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/timeout_counter.sv
// Saturating cycle counter with synchronous clear; flags the last allowed wait cycle.
module timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc_c
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && (r_cnt != CNT_W'(TIMEOUT))) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // High during the TIMEOUT-th enabled cycle, so the abort lands after exactly TIMEOUT cycles.
  assign o_tc_c = (r_cnt >= CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/sdram_access_port.sv
// Single-outstanding SDRAM access port: turns read/write pulses into Avalon-MM
// transactions, with a one-entry pending slot and a read-data timeout.
module sdram_access_port
  import sdram_access_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst,
  sdram_access_port_if.master bus
);
  state_t            r_state, w_next;
  logic              r_pend_valid, r_pend_write;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [DATA_W-1:0] r_pend_data;
  logic [DATA_W-1:0] r_read_data;
  logic              r_data_read, r_write_done, r_busy, r_timeout_err, r_overrun_err;
  logic [ADDR_W-1:0] r_avm_address;
  logic              r_avm_read, r_avm_write;
  logic [DATA_W-1:0] r_avm_writedata;

  logic              w_tc, w_new_req, w_issue_pend, w_issue_new, w_issue, w_issue_write;
  logic              w_store, w_slot_free, w_drop, w_next_pend_valid;
  logic [ADDR_W-1:0] w_issue_addr;
  logic [DATA_W-1:0] w_issue_data;

  timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (r_state != RD_WAIT),
    .i_enable (r_state == RD_WAIT),
    .o_tc_c   (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Issue selection, pending-slot bookkeeping and next state.
  always_comb begin
    w_next            = r_state;
    w_new_req         = bus.read_en | bus.write_en;
    w_issue_pend      = r_pend_valid && ((r_state == IDLE) || (r_state == DONE));
    w_issue_new       = (r_state == IDLE) && !r_pend_valid && w_new_req;
    w_issue           = w_issue_pend | w_issue_new;
    w_issue_write     = w_issue_pend ? r_pend_write : !bus.read_en;
    w_issue_addr      = w_issue_pend ? r_pend_addr  : bus.address;
    w_issue_data      = w_issue_pend ? r_pend_data  : bus.write_data;
    w_store           = w_new_req && !w_issue_new;
    w_slot_free       = !r_pend_valid || w_issue_pend;
    w_drop            = (w_store && !w_slot_free) || (bus.read_en && bus.write_en);
    w_next_pend_valid = (w_store && w_slot_free) || (r_pend_valid && !w_issue_pend);
    case (r_state)
      IDLE, DONE: w_next = w_issue ? (w_issue_write ? WR_REQ : RD_REQ) : IDLE;
      RD_REQ:     if (!bus.avm_waitrequest) w_next = RD_WAIT;
      RD_WAIT:    if (bus.avm_readdatavalid || w_tc) w_next = DONE;
      WR_REQ:     if (!bus.avm_waitrequest) w_next = DONE;
      default:    w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend_valid    <= 1'b0;
      r_pend_write    <= 1'b0;
      r_pend_addr     <= '0;
      r_pend_data     <= '0;
      r_read_data     <= '0;
      r_data_read     <= 1'b0;
      r_write_done    <= 1'b0;
      r_busy          <= 1'b0;
      r_timeout_err   <= 1'b0;
      r_overrun_err   <= 1'b0;
      r_avm_address   <= '0;
      r_avm_read      <= 1'b0;
      r_avm_write     <= 1'b0;
      r_avm_writedata <= '0;
    end else begin
      r_avm_read   <= (w_next == RD_REQ);
      r_avm_write  <= (w_next == WR_REQ);
      if (w_issue) begin
        r_avm_address   <= w_issue_addr;
        r_avm_writedata <= w_issue_data;
      end
      r_data_read  <= (r_state == RD_WAIT) && (bus.avm_readdatavalid || w_tc);
      r_write_done <= (r_state == WR_REQ) && !bus.avm_waitrequest;
      // Real data wins over a timeout landing on the same cycle.
      if (r_state == RD_WAIT) begin
        if (bus.avm_readdatavalid) begin
          r_read_data <= bus.avm_readdata;
        end else if (w_tc) begin
          r_read_data   <= '0;
          r_timeout_err <= 1'b1;
        end
      end
      if (w_drop) r_overrun_err <= 1'b1;
      r_busy       <= (w_next != IDLE) || w_next_pend_valid;
      r_pend_valid <= w_next_pend_valid;
      if (w_store && w_slot_free) begin
        r_pend_write <= !bus.read_en;
        r_pend_addr  <= bus.address;
        r_pend_data  <= bus.write_data;
      end
    end
  end

  assign bus.read_data     = r_read_data;
  assign bus.data_read     = r_data_read;
  assign bus.write_done    = r_write_done;
  assign bus.busy          = r_busy;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.overrun_err   = r_overrun_err;
  assign bus.avm_address   = r_avm_address;
  assign bus.avm_read      = r_avm_read;
  assign bus.avm_write     = r_avm_write;
  assign bus.avm_writedata = r_avm_writedata;

endmodule

// File: tb/tb_sdram_access_port.sv
// Directed bench for sdram_access_port; completions are checked by a queue-based monitor.
module tb_sdram_access_port;

  typedef struct packed {
    logic        is_write;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   c0;
  exp_t q[$];

  sdram_access_port_if #(.ADDR_W(24), .DATA_W(32)) bus ();

  sdram_access_port #(.ADDR_W(24), .DATA_W(32), .TIMEOUT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every completion pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (bus.data_read || bus.write_done) begin
      chk("pulse_expected", 64'(q.size() != 0), 64'(1));
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("pulse_kind", 64'(bus.write_done), 64'(e.is_write));
        chk("pulse_cycle", 64'(cyc), 64'(e.cyc));
        if (!e.is_write) chk("read_data", 64'(bus.read_data), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.read_en = 1'b0; bus.write_en = 1'b0;
    bus.address = '0;   bus.write_data = '0;
    bus.avm_readdata = '0; bus.avm_readdatavalid = 1'b0; bus.avm_waitrequest = 1'b0;
    step(2);
    chk("rst_read_data", 64'(bus.read_data), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_avm_read", 64'(bus.avm_read), 64'(0));
    chk("rst_avm_write", 64'(bus.avm_write), 64'(0));
    chk("rst_errs", 64'({bus.timeout_err, bus.overrun_err}), 64'(0));
    rst = 1'b0;
    step;

    // Minimum-latency read.
    c0 = cyc;
    bus.read_en = 1'b1; bus.address = 24'h000010;
    q.push_back('{1'b0, 32'hDEADBEEF, c0 + 3});
    step; bus.read_en = 1'b0;
    chk("rd_avm_read", 64'(bus.avm_read), 64'(1));
    chk("rd_avm_address", 64'(bus.avm_address), 64'h10);
    chk("rd_avm_write", 64'(bus.avm_write), 64'(0));
    chk("rd_busy", 64'(bus.busy), 64'(1));
    step;
    chk("rd_avm_read_off", 64'(bus.avm_read), 64'(0));
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hDEADBEEF;
    step; bus.avm_readdatavalid = 1'b0;
    step;
    chk("rd_pulse_once", 64'(bus.data_read), 64'(0));
    chk("rd_idle_busy", 64'(bus.busy), 64'(0));

    // Minimum-latency write.
    c0 = cyc;
    bus.write_en = 1'b1; bus.address = 24'h000030; bus.write_data = 32'hA5A5A5A5;
    q.push_back('{1'b1, 32'h0, c0 + 2});
    step; bus.write_en = 1'b0;
    chk("wr0_avm_write", 64'(bus.avm_write), 64'(1));
    chk("wr0_avm_writedata", 64'(bus.avm_writedata), 64'hA5A5A5A5);
    step;
    chk("wr0_avm_write_off", 64'(bus.avm_write), 64'(0));
    step;

    // Write stalled by waitrequest for 4 cycles.
    c0 = cyc;
    bus.write_en = 1'b1; bus.address = 24'h000020; bus.write_data = 32'h12345678;
    bus.avm_waitrequest = 1'b1;
    q.push_back('{1'b1, 32'h0, c0 + 6});
    for (int i = 1; i <= 5; i++) begin
      step; bus.write_en = 1'b0;
      chk("wr_hold_write", 64'(bus.avm_write), 64'(1));
      chk("wr_hold_addr", 64'(bus.avm_address), 64'h20);
      chk("wr_hold_data", 64'(bus.avm_writedata), 64'h12345678);
      if (i == 5) bus.avm_waitrequest = 1'b0;
    end
    step;
    chk("wr_write_off", 64'(bus.avm_write), 64'(0));
    step;

    // Read with readdatavalid withheld: abort after 8 wait cycles.
    c0 = cyc;
    bus.read_en = 1'b1; bus.address = 24'h000040;
    q.push_back('{1'b0, 32'h0, c0 + 10});
    step; bus.read_en = 1'b0;
    step(8);
    chk("to_err_before", 64'(bus.timeout_err), 64'(0));
    step;
    chk("to_err_set", 64'(bus.timeout_err), 64'(1));
    step;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hBAD0BAD0;
    step; bus.avm_readdatavalid = 1'b0;
    step(2);
    chk("to_late_ignored", 64'(bus.read_data), 64'(0));
    chk("to_err_sticky", 64'(bus.timeout_err), 64'(1));

    // Write queued during RD_WAIT, third request dropped.
    c0 = cyc;
    bus.read_en = 1'b1; bus.address = 24'h000050;
    q.push_back('{1'b0, 32'hCAFE0001, c0 + 5});
    step; bus.read_en = 1'b0;
    step;
    bus.write_en = 1'b1; bus.address = 24'h000060; bus.write_data = 32'h0BADF00D;
    step; bus.write_en = 1'b0;
    chk("ov_err_before", 64'(bus.overrun_err), 64'(0));
    chk("ov_busy", 64'(bus.busy), 64'(1));
    bus.read_en = 1'b1; bus.address = 24'h000070;
    step; bus.read_en = 1'b0;
    chk("ov_err_set", 64'(bus.overrun_err), 64'(1));
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'hCAFE0001;
    q.push_back('{1'b1, 32'h0, c0 + 7});
    step; bus.avm_readdatavalid = 1'b0;
    step;
    chk("pend_avm_write", 64'(bus.avm_write), 64'(1));
    chk("pend_avm_addr", 64'(bus.avm_address), 64'h60);
    chk("pend_avm_data", 64'(bus.avm_writedata), 64'h0BADF00D);
    chk("pend_avm_read", 64'(bus.avm_read), 64'(0));
    step(2);
    chk("pend_busy_done", 64'(bus.busy), 64'(0));
    chk("pend_no_third", 64'(bus.avm_read), 64'(0));
    step;
    chk("pend_no_third2", 64'(bus.avm_read), 64'(0));

    // Reset in the middle of a stalled write.
    bus.write_en = 1'b1; bus.address = 24'h000080; bus.write_data = 32'h00000077;
    bus.avm_waitrequest = 1'b1;
    step; bus.write_en = 1'b0;
    chk("mr_avm_write", 64'(bus.avm_write), 64'(1));
    step;
    rst = 1'b1;
    #1;
    chk("mr_avm_write_off", 64'(bus.avm_write), 64'(0));
    chk("mr_busy", 64'(bus.busy), 64'(0));
    chk("mr_avm_addr", 64'(bus.avm_address), 64'(0));
    chk("mr_errs_clear", 64'({bus.timeout_err, bus.overrun_err}), 64'(0));
    step;
    rst = 1'b0; bus.avm_waitrequest = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("mr_no_write_done", 64'(bus.write_done), 64'(0));
      chk("mr_no_avm_write", 64'(bus.avm_write), 64'(0));
    end

    // Simultaneous read and write: read wins.
    c0 = cyc;
    bus.read_en = 1'b1; bus.write_en = 1'b1;
    bus.address = 24'h000090; bus.write_data = 32'h11111111;
    q.push_back('{1'b0, 32'h22222222, c0 + 3});
    step; bus.read_en = 1'b0; bus.write_en = 1'b0;
    chk("both_avm_read", 64'(bus.avm_read), 64'(1));
    chk("both_avm_write", 64'(bus.avm_write), 64'(0));
    chk("both_avm_addr", 64'(bus.avm_address), 64'h90);
    chk("both_overrun", 64'(bus.overrun_err), 64'(1));
    step;
    bus.avm_readdatavalid = 1'b1; bus.avm_readdata = 32'h22222222;
    step; bus.avm_readdatavalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step;
      chk("both_no_write", 64'(bus.avm_write), 64'(0));
    end
    chk("both_idle_busy", 64'(bus.busy), 64'(0));

    step(3);
    chk("queue_drained", 64'(q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
